// File: rtl/axis_fifo_pkg.sv
// Shared constants and helpers for the single-clock AXI-Stream FIFO.
package axis_fifo_pkg;

  localparam int COUNT_W = 32;

  // Pointers carry one extra bit so that full and empty can be told apart.
  function automatic int ptr_w(input int awidth);
    return awidth + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// DEPTH x (DWIDTH+1) storage: synchronous write, asynchronous read, no reset on the array.
module axis_fifo_ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH:0]   wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH:0]   rdata
);

  logic [DWIDTH:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo_sync.sv
// Single-clock AXI-Stream FIFO with first-word fall-through and live occupancy.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward release of whole packets.
module axis_fifo_sync
  import axis_fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic [DWIDTH-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [COUNT_W-1:0] axis_wr_data_count,
  output logic [DWIDTH-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [COUNT_W-1:0] axis_rd_data_count
);

  localparam int PTR_W = ptr_w(AWIDTH);
  localparam int DEPTH = 2**AWIDTH;

  typedef struct packed {
    logic              last;
    logic [DWIDTH-1:0] data;
  } entry_t;

  // Handshake rule on both sides: a word moves only on an edge where valid && ready.
  logic [PTR_W-1:0] wr_ptr, rd_ptr, count;
  logic             rst_done;
  logic             full, empty, wr_en, rd_en;
  entry_t           wr_entry, head;

  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == PTR_W'(DEPTH));
  assign empty  = (count == '0);

  assign s_axis_tready = !full && rst_done;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign rd_en         = m_axis_tvalid && m_axis_tready;

  assign wr_entry.last = s_axis_tlast;
  assign wr_entry.data = s_axis_tdata;

  axis_fifo_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk   (s_axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr[AWIDTH-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AWIDTH-1:0]),
    .rdata (head)
  );

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [PTR_W-1:0] pkt_count;
  logic             pkt_in, pkt_out;

  assign pkt_in  = wr_en && s_axis_tlast;
  assign pkt_out = rd_en && head.last;

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      pkt_count <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_count <= pkt_count + PTR_W'(1);
    end else if (!pkt_in && pkt_out) begin
      pkt_count <= pkt_count - PTR_W'(1);
    end
  end

  // A full FIFO with no complete packet would deadlock; let it cut through instead.
  assign m_axis_tvalid = !empty && ((pkt_count != '0) || full);
`else
  assign m_axis_tvalid = !empty;
`endif

  assign m_axis_tdata = head.data;
  assign m_axis_tlast = m_axis_tvalid && head.last;

  assign axis_wr_data_count = COUNT_W'(count);
  assign axis_rd_data_count = COUNT_W'(count);

endmodule

// File: tb/tb_axis_fifo_sync.sv
// Directed self-checking bench for axis_fifo_sync (AWIDTH=2, DWIDTH=8); follows
// the build's AXIS_FIFO_PACKET_MODE_EN setting for the expected valid timing.
module tb_axis_fifo_sync;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 2**AW;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [31:0]   wr_count, rd_count;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  int vec_cnt = 0;
  int err_cnt = 0;
  int last_seen = 0;
  logic [DW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axis_fifo_sync #(
    .DWIDTH(DW),
    .AWIDTH(AW)
  ) dut (
    .s_axis_aclk        (clk),
    .s_axis_aresetn     (aresetn),
    .s_axis_tdata       (s_tdata),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tready      (s_tready),
    .s_axis_tlast       (s_tlast),
    .axis_wr_data_count (wr_count),
    .m_axis_tdata       (m_tdata),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tlast       (m_tlast),
    .axis_rd_data_count (rd_count)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_counts(input string tag, input int exp);
    check({tag, "_wr_cnt"}, wr_count, exp);
    check({tag, "_rd_cnt"}, rd_count, exp);
  endtask

  // Scoreboard: observe handshakes mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (aresetn === 1'b1) begin
      if (s_tvalid && s_tready) exp_q.push_back({s_tlast, s_tdata});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("sb_data", 32'(m_tdata), 32'(e[DW-1:0]));
          check("sb_last", 32'(m_tlast), 32'(e[DW]));
          if (m_tlast) last_seen++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
  endtask

  task automatic idle_writer();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int cycles);
    idle_writer();
    m_tready = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] d;

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b0;
    idle_writer();
    tick();
    tick();

    // Reset state
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_tlast),  32'd0);
    check_counts("rst", 0);

    aresetn = 1'b1;
    check("pre_release_tready", 32'(s_tready), 32'd0);
    tick();
    check("release_tready", 32'(s_tready), 32'd1);

    // 0x01..0x04 back-to-back, reader ready
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_word(DW'(i + 1), i == 3);
      tick();
      if (i == 0) begin
        check("ffwt_tvalid", 32'(m_tvalid), PKT ? 32'd0 : 32'd1);
        if (!PKT) check("ffwt_tdata", 32'(m_tdata), 32'h01);
      end
    end
    drain(6);
    check_counts("b2b_end", 0);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Fill to full with reader stalled; fifth word must wait
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_word(DW'(8'h10 + i), 1'b0);
      tick();
    end
    check("full_tready", 32'(s_tready), 32'd0);
    check_counts("full", 4);
    drive_word(8'h14, 1'b1);
    tick();
    check("full_hold_tready", 32'(s_tready), 32'd0);
    check_counts("full_hold", 4);
    check("full_tvalid", 32'(m_tvalid), 32'd1);
    check("full_head", 32'(m_tdata), 32'h10);
    m_tready = 1'b1;
    tick();
    check("unfull_tready", 32'(s_tready), 32'd1);
    check_counts("unfull", 3);
    tick();
    check_counts("fifth_in", PKT ? 4 : 3);
    drain(8);
    check_counts("full_end", 0);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Prefill two, then 3*DEPTH words with simultaneous read/write (pointer wrap)
    m_tready = 1'b0;
    drive_word(8'hA0, 1'b1); tick();
    drive_word(8'hA1, 1'b1); tick();
    check_counts("prefill", 2);
    m_tready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      d = DW'(8'h40 + i * 7);
      drive_word(d, (i % 3) == 2);
      tick();
      if (!PKT) check_counts("stream", 2);
    end
    drain(8);
    check_counts("stream_end", 0);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Three-word packet: valid timing depends on store-and-forward
    m_tready = 1'b1;
    drive_word(8'hC0, 1'b0); tick();
    check("pkt3_v0", 32'(m_tvalid), PKT ? 32'd0 : 32'd1);
    drive_word(8'hC1, 1'b0); tick();
    check("pkt3_v1", 32'(m_tvalid), PKT ? 32'd0 : 32'd1);
    drive_word(8'hC2, 1'b1); tick();
    check("pkt3_v2", 32'(m_tvalid), 32'd1);
    drain(6);
    check_counts("pkt3_end", 0);

    // Six-word packet longer than DEPTH
    last_seen = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_word(DW'(8'hD0 + i), i == 5);
      for (int t = 0; t < 20; t++) begin
        tick();
        if (exp_q.size() > 0 && exp_q[$] == {i == 5, DW'(8'hD0 + i)}) break;
        if (t == 19) check("pkt6_accept_timeout", 32'(i), 32'hFFFF);
      end
    end
    drain(10);
    check_counts("pkt6_end", 0);
    check("pkt6_last_seen", 32'(last_seen), 32'd1);
    check("pkt6_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-packet with three words stored
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(DW'(8'hE0 + i), 1'b0);
      tick();
    end
    check_counts("pre_rst", 3);
    idle_writer();
    aresetn = 1'b0;
    exp_q.delete();
    tick();
    check_counts("mid_rst", 0);
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_tready", 32'(s_tready), 32'd0);
    aresetn = 1'b1;
    tick();
    check("post_rst_tready", 32'(s_tready), 32'd1);
    m_tready = 1'b1;
    drive_word(8'h77, 1'b1);
    tick();
    check("post_rst_tvalid", 32'(m_tvalid), 32'd1);
    check("post_rst_head", 32'(m_tdata), 32'h77);
    drain(4);
    check_counts("final", 0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axis_fifo_sync.md
# axis_fifo_sync

Single-clock, parametrised AXI-Stream FIFO with inferred LUT-RAM storage, tlast carried per word, live occupancy counts and an optional store-and-forward packet mode. Successor to the vendor-IP FIFO wrapper for all same-clock buffering between the readout front-end and the packetiser/UART path. Handshakes are AXIS-compliant: transfer only on valid && ready.

## Interface
- DWIDTH, 8, tdata width in bits (≥1)
- AWIDTH, 8, address width; DEPTH = 2**AWIDTH words (AWIDTH 2..10)

- s_axis_aclk  in  1  sole clock for both sides
- s_axis_aresetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DWIDTH  write data
- s_axis_tvalid  in  1  write valid
- s_axis_tready  out  1  write ready
- s_axis_tlast  in  1  end-of-packet marker, stored with word
- axis_wr_data_count  out  32  occupancy, zero-extended
- m_axis_tdata  out  DWIDTH  read data (head word)
- m_axis_tvalid  out  1  read valid
- m_axis_tready  in  1  read ready
- m_axis_tlast  out  1  tlast of head word
- axis_rd_data_count  out  32  occupancy, identical to axis_wr_data_count

## Operation
- Pointers wr_ptr/rd_ptr are AWIDTH+1 bits; count = wr_ptr − rd_ptr (mod 2**(AWIDTH+1)), range 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- s_axis_tready = !full && !in_reset (registered reset-release flag).
- Write handshake (tvalid && tready): mem[wr_ptr[AWIDTH-1:0]] ← {tlast, tdata}; wr_ptr++.
- m_axis_tdata/m_axis_tlast driven combinationally from mem[rd_ptr[AWIDTH-1:0]]; undefined while m_axis_tvalid low.
- Read handshake (tvalid && tready): rd_ptr++.
- Simultaneous write and read: both pointers advance, count unchanged. Write while full and read while empty cannot occur (ready/valid low).
- Pointer wrap: natural modulo on AWIDTH+1 bits; no special case.
- Data counts are the same registered count, zero-extended to 32 bits.
- Reset (synchronous, any time, including mid-packet): pointers, count, pkt_count cleared; contents discarded; partial packets lost.

## Timing
- Write-to-read latency: word accepted at edge N is visible with m_axis_tvalid = 1 after edge N (first-word fall-through, 1 cycle).
- Count updates on the edge following the handshake.
- Reset values (cycle after sampled low): s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, both counts 0. s_axis_tready rises on the first edge with s_axis_aresetn high sampled.
- Full→not full: s_axis_tready rises the cycle after the read handshake that frees an entry.
- Sustained throughput: 1 word/cycle both sides when neither full nor empty.

## Configuration
- AXIS_FIFO_PACKET_MODE_EN defined: store-and-forward. pkt_count (AWIDTH+1 bits) +1 on write handshake with tlast, −1 on read handshake with head tlast; both same cycle → unchanged. m_axis_tvalid = !empty && (pkt_count != 0 || full). The full override releases a packet longer than DEPTH in cut-through fashion to prevent deadlock.
- Not defined: m_axis_tvalid = !empty; pkt_count logic absent; tlast still stored and passed through.

## Structure
- Package axis_fifo_pkg: ptr_t width helper function (AWIDTH+1), COUNT_W = 32 constant, entry struct {last, data} parametrised via DWIDTH at use site.
- Sub-module axis_fifo_ram: DEPTH×(DWIDTH+1) LUT RAM, synchronous write, asynchronous read; no reset on array.
- Top holds pointers, count, pkt_count, handshake logic.

## Test plan
- Reset release, then 8-bit words 0x01..0x04 written back-to-back with tready=1 -> m_axis_tvalid at cycle after first write, output 0x01..0x04 in order, counts return to 0.
- AWIDTH=2: write 5 words with m_axis_tready=0 -> 4 accepted, s_axis_tready 0 from cycle after 4th, counts = 4; one read -> tready 1 next cycle, 5th word accepted.
- Continuous simultaneous read/write for 3·DEPTH words with random data -> pointer wrap, count constant, scoreboard match, tlast positions preserved.
- Packet mode: write 3 words, tlast on 3rd, reader ready -> m_axis_tvalid 0 until cycle after 3rd write, then 3 words with tlast on last; non-packet build -> first word out 1 cycle after write.
- Packet mode, AWIDTH=2: 6-word packet -> tvalid forced at full, all 6 words delivered, tlast on 6th, pkt_count ends 0.
- Assert s_axis_aresetn low for 1 cycle with count = 3 mid-packet -> next cycle counts 0, m_axis_tvalid 0, tready 0; subsequent write emerges as first output.
